// File: rtl/mmio_uart.sv
// -----------------------------------------------------------------------------
// mmio_uart
//   Memory-mapped 8N1 UART peripheral that sits on the MEM-stage data bus next
//   to the data memory. Three word registers are decoded from the byte address:
//     BASE_ADDR + 0 : UART_TXD  (R/W, write starts a frame when allowed)
//     BASE_ADDR + 4 : UART_RXD  (R,   read clears rx_valid)
//     BASE_ADDR + 8 : UART_CON  (R/W, read clears tx_done, write sets [1:0])
//   UART_CON = {tx_busy, rx_valid, tx_done, tx_en, rx_en}.
//
// Ports
//   clk         system clock, all state updates on the rising edge
//   reset       synchronous, active-low reset
//   Address     MEM-stage byte address
//   Write_data  store data ([7:0] for TXD, [1:0] for CON)
//   MemRead     load strobe for this cycle
//   MemWrite    store strobe for this cycle
//   Read_data   combinational, zero-extended read data (0 when not selected)
//   hit         Address matches one of the three registers exactly
//   uart_rx     asynchronous serial input
//   uart_tx     serial output, idles high
//   UART_TXD    last accepted transmit byte
//   UART_RXD    last correctly framed received byte
//   UART_CON    control/status register
// -----------------------------------------------------------------------------
module mmio_uart #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] Read_data,
  output logic        hit,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic [7:0]  UART_TXD,
  output logic [7:0]  UART_RXD,
  output logic [4:0]  UART_CON
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Last count of a full bit period, and of the half period used to land the
  // receiver's sampling point in the middle of each bit.
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [31:0] TXD_ADDR = BASE_ADDR;
  localparam logic [31:0] RXD_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0] CON_ADDR = BASE_ADDR + 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic sel_txd, sel_rxd, sel_con;
  logic rd_rxd, rd_con, wr_txd, wr_con;

  // Exact word-address compare: misaligned addresses never select a register.
  assign sel_txd = (Address == TXD_ADDR);
  assign sel_rxd = (Address == RXD_ADDR);
  assign sel_con = (Address == CON_ADDR);
  assign hit     = sel_txd | sel_rxd | sel_con;

  assign rd_rxd  = sel_rxd & MemRead;
  assign rd_con  = sel_con & MemRead;
  assign wr_txd  = sel_txd & MemWrite;
  assign wr_con  = sel_con & MemWrite;

  // Only the low byte of store data is ever consumed.
  logic unused_wdata;
  assign unused_wdata = ^Write_data[31:8];

  // ---------------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------------
  logic          rx_en_q, rx_en_d;
  logic          tx_en_q, tx_en_d;
  logic          tx_done_q, tx_done_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    txd_q, txd_d;
  logic [7:0]    rxd_q, rxd_d;
  logic          tx_busy;

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_start;
  logic          tx_complete;

  logic          rx_sync1_q, rx_sync2_q;
  uart_state_e   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_done;

  // The transmitter is busy exactly while its FSM is outside IDLE; the accept
  // edge moves it to START, and the final STOP edge returns it to IDLE.
  assign tx_busy  = (tx_state_q != ST_IDLE);

  assign UART_CON = {tx_busy, rx_valid_q, tx_done_q, tx_en_q, rx_en_q};
  assign UART_TXD = txd_q;
  assign UART_RXD = rxd_q;
  assign uart_tx  = tx_line_q;

  // ---------------------------------------------------------------------------
  // Read data mux
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so
    // that no path leaves it unassigned, which would infer a latch.
    Read_data = '0;
    if (MemRead) begin
      if (sel_txd)      Read_data = {24'b0, txd_q};
      else if (sel_rxd) Read_data = {24'b0, rxd_q};
      else if (sel_con) Read_data = {27'b0, UART_CON};
    end
  end

  // ---------------------------------------------------------------------------
  // Control/status next state
  // ---------------------------------------------------------------------------
  // A TXD write only starts a frame when enabled and idle; otherwise it is
  // dropped entirely.
  assign tx_start = wr_txd & tx_en_q & ~tx_busy;

  always_comb begin
    rx_en_d    = rx_en_q;
    tx_en_d    = tx_en_q;
    txd_d      = txd_q;
    rxd_d      = rxd_q;
    tx_done_d  = tx_done_q;
    rx_valid_d = rx_valid_q;

    if (wr_con) begin
      rx_en_d = Write_data[0];
      tx_en_d = Write_data[1];
    end

    if (tx_start) txd_d = Write_data[7:0];

    // Status set beats the read-clear when both land on the same edge.
    if (tx_complete)  tx_done_d = 1'b1;
    else if (rd_con)  tx_done_d = 1'b0;

    if (rx_done) begin
      rxd_d      = rx_shift_q;
      rx_valid_d = 1'b1;
    end else if (rd_rxd) begin
      rx_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // TX FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_complete = 1'b0;

    unique case (tx_state_q)
      ST_IDLE: begin
        if (tx_start) begin
          tx_state_d = ST_START;
          tx_cnt_d   = '0;
        end
      end
      ST_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_state_d  = ST_IDLE;
          tx_cnt_d    = '0;
          tx_complete = 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase

    // The serial line is registered from the next state so the pin changes
    // on the same edge as the state and never glitches on decode.
    unique case (tx_state_d)
      ST_START: tx_line_d = 1'b0;
      ST_DATA:  tx_line_d = txd_d[tx_bit_d];
      default:  tx_line_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RX FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done    = 1'b0;

    if (!rx_en_q) begin
      rx_state_d = ST_IDLE;
      rx_cnt_d   = '0;
      rx_bit_d   = 3'd0;
    end else begin
      unique case (rx_state_q)
        ST_IDLE: begin
          if (!rx_sync2_q) begin
            rx_state_d = ST_START;
            rx_cnt_d   = '0;
          end
        end
        ST_START: begin
          // Re-check the line half a bit in; a high level means the falling
          // edge was a glitch, not a start bit.
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            if (rx_sync2_q) begin
              rx_state_d = ST_IDLE;
            end else begin
              rx_state_d = ST_DATA;
              rx_bit_d   = 3'd0;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_state_d = ST_IDLE;
            // A low stop bit is a framing error: the byte is dropped.
            rx_done    = rx_sync2_q;
          end else begin
            rx_cnt_d = rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled synchronously here, so it only takes effect on a
    // clock edge and aborts any frame in flight at that edge.
    if (!reset) begin
      rx_en_q    <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_done_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      txd_q      <= '0;
      rxd_q      <= '0;
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_line_q  <= 1'b1;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= '0;
    end else begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs, e.g. the two synchronizer flops.
      rx_en_q    <= rx_en_d;
      tx_en_q    <= tx_en_d;
      tx_done_q  <= tx_done_d;
      rx_valid_q <= rx_valid_d;
      txd_q      <= txd_d;
      rxd_q      <= rxd_d;
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

endmodule

// File: tb/tb_mmio_uart.sv
// -----------------------------------------------------------------------------
// tb_mmio_uart
//   Directed self-checking bench for mmio_uart with CLKS_PER_BIT = 4.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mmio_uart;

  localparam int          CPB   = 4;
  localparam logic [31:0] TXD_A = 32'h4000_0018;
  localparam logic [31:0] RXD_A = 32'h4000_001C;
  localparam logic [31:0] CON_A = 32'h4000_0020;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Address = '0;
  logic [31:0] Write_data = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Read_data;
  logic        hit;
  logic        uart_rx = 1'b1;
  logic        uart_tx;
  logic [7:0]  UART_TXD;
  logic [7:0]  UART_RXD;
  logic [4:0]  UART_CON;

  int n_checks = 0;
  int n_errors = 0;

  mmio_uart #(
    .CLKS_PER_BIT(CPB),
    .BASE_ADDR   (TXD_A)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Read_data (Read_data),
    .hit       (hit),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .UART_TXD  (UART_TXD),
    .UART_RXD  (UART_RXD),
    .UART_CON  (UART_CON)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Store: drive at a falling edge, committed by the following rising edge.
  task automatic write_reg(input logic [31:0] addr, input logic [31:0] data);
    Address    = addr;
    Write_data = data;
    MemWrite   = 1'b1;
    @(negedge clk);
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
  endtask

  // Load: sample the combinational data, then let the side-effect edge pass.
  task automatic read_reg(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data = Read_data;
    @(negedge clk);
    MemRead = 1'b0;
    Address = '0;
  endtask

  // Expected line level for cycle i after the accept edge of byte b.
  function automatic logic tx_level(input logic [7:0] b, input int i);
    logic [2:0] idx;
    if (i < CPB) return 1'b0;
    if (i >= 9 * CPB) return 1'b1;
    idx = 3'((i - CPB) / CPB);
    return b[idx];
  endfunction

  // Checks a whole frame cycle by cycle. When poke is set, a TXD write of
  // 0x5A is attempted at cycle 10, while the frame is busy.
  task automatic run_frame(input logic [7:0] b, input bit poke, input string tag);
    int low_err;
    int busy_err;
    low_err  = 0;
    busy_err = 0;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (uart_tx !== tx_level(b, i)) low_err++;
      if (UART_CON[4] !== 1'b1) busy_err++;
      if (poke && i == 10) begin
        Address    = TXD_A;
        Write_data = 32'h0000_005A;
        MemWrite   = 1'b1;
      end else if (poke && i == 11) begin
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
      end
      @(negedge clk);
    end
    check({tag, "_wave_errs"}, low_err, 0);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_busy_end"}, {31'b0, UART_CON[4]}, 32'd0);
    check({tag, "_done_set"}, {31'b0, UART_CON[2]}, 32'd1);
    check({tag, "_line_idle"}, {31'b0, uart_tx}, 32'd1);
  endtask

  // Drive one serial frame at CPB cycles per bit, then idle the line.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  logic [31:0] rd;
  logic [31:0] hit_addr [7];
  logic        hit_exp  [7];
  int          extra_activity;

  initial begin
    hit_addr = '{32'h4000_0018, 32'h4000_001C, 32'h4000_0020, 32'h4000_0014,
                 32'h4000_0024, 32'h4000_0019, 32'h0000_0018};
    hit_exp  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // 1. Reset state and address decode
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_con", {27'b0, UART_CON}, 32'd0);
    check("rst_txd", {24'b0, UART_TXD}, 32'd0);
    check("rst_rxd", {24'b0, UART_RXD}, 32'd0);
    read_reg(CON_A, rd);
    check("rst_con_read", rd, 32'd0);
    for (int i = 0; i < 7; i++) begin
      Address = hit_addr[i];
      #1;
      check($sformatf("hit_%08h", hit_addr[i]), {31'b0, hit}, {31'b0, hit_exp[i]});
    end
    Address = 32'h4000_0019;
    MemRead = 1'b1;
    #1;
    check("misaligned_read", Read_data, 32'd0);
    @(negedge clk);
    MemRead = 1'b0;
    Address = '0;

    // 2./3. Transmit 0xA5, with a rejected TXD write while busy
    write_reg(CON_A, 32'h0000_0003);
    check("con_after_write", {27'b0, UART_CON}, 32'h03);
    write_reg(TXD_A, 32'h0000_00A5);
    run_frame(8'hA5, 1'b1, "tx_a5");
    check("txd_kept", {24'b0, UART_TXD}, 32'hA5);
    extra_activity = 0;
    repeat (44) begin
      if (uart_tx !== 1'b1 || UART_CON[4] !== 1'b0) extra_activity++;
      @(negedge clk);
    end
    check("no_second_frame", extra_activity, 0);
    read_reg(TXD_A, rd);
    check("txd_read", rd, 32'hA5);
    read_reg(CON_A, rd);
    check("con_read_done", rd, 32'h07);
    read_reg(CON_A, rd);
    check("con_read_cleared", rd, 32'h03);

    // 4. Receive 0x3C
    send_rx(8'h3C, 1'b1);
    check("rx_valid_set", {31'b0, UART_CON[3]}, 32'd1);
    read_reg(RXD_A, rd);
    check("rxd_read", rd, 32'h3C);
    check("rx_valid_cleared", {31'b0, UART_CON[3]}, 32'd0);
    check("rxd_port", {24'b0, UART_RXD}, 32'h3C);

    // 5. Glitch, then framing error
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_valid", {31'b0, UART_CON[3]}, 32'd0);
    check("glitch_rxd", {24'b0, UART_RXD}, 32'h3C);
    send_rx(8'h55, 1'b0);
    check("frame_err_valid", {31'b0, UART_CON[3]}, 32'd0);
    check("frame_err_rxd", {24'b0, UART_RXD}, 32'h3C);

    // 6. Reset in the middle of bit 3 of a frame
    write_reg(TXD_A, 32'h0000_0096);
    repeat (17) @(negedge clk);
    check("mid_frame_bit3", {31'b0, uart_tx}, 32'd0);
    check("mid_frame_busy", {31'b0, UART_CON[4]}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("abort_con", {27'b0, UART_CON}, 32'd0);
    check("abort_txd", {24'b0, UART_TXD}, 32'd0);
    write_reg(CON_A, 32'h0000_0002);
    write_reg(TXD_A, 32'h0000_0081);
    run_frame(8'h81, 1'b0, "tx_81");
    check("txd_after_abort", {24'b0, UART_TXD}, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
